// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the byte stream from a PS/2 receiver into complete key events.
//   It also tracks two-player headings and produces start/escape pulses.
//   Each byte uses a level/acknowledge handshake. The block captures a byte
//   while scan_ready is high in IDLE and answers with a one-cycle read pulse.
//   It then waits for scan_ready to drop before it accepts another byte.
//   E0 (extended) and F0 (break) prefixes are remembered until the final code
//   arrives, or until PREFIX_TIMEOUT cycles pass with no following byte.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   scan_code    byte from the receiver, valid while scan_ready = 1
//   scan_ready   receiver has a byte; held high until acknowledged
//   read         one-cycle acknowledge to the receiver
//   key_valid    one-cycle pulse: key_code/key_break/key_ext hold a new event
//   key_code     final scan code of the last event
//   key_break    1 = release, 0 = press
//   key_ext      1 = event carried an E0 prefix
//   p1_dir       player-1 heading (00 up, 01 right, 10 down, 11 left)
//   p2_dir       player-2 heading, same encoding
//   start_pulse  one-cycle pulse on Space press
//   esc_pulse    one-cycle pulse on Escape press
module ps2_key_decoder #(
  parameter int unsigned PREFIX_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_ready,
  output logic       read,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       start_pulse,
  output logic       esc_pulse
);

  typedef enum logic {IDLE, WAIT_CLR} state_t;

  state_t      state_q, state_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [15:0] timer_q, timer_d;
  logic        read_q, read_d;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        key_break_q, key_break_d;
  logic        key_ext_q, key_ext_d;
  logic [1:0]  p1_q, p1_d;
  logic [1:0]  p2_q, p2_d;
  logic        start_q, start_d;
  logic        esc_q, esc_d;

  // Requested heading for each player, valid only when the *_req_v flag is set.
  logic        p1_req_v, p2_req_v;
  logic [1:0]  p1_req, p2_req;

  always_comb begin
    p1_req_v = 1'b1;
    p1_req   = 2'b00;
    case (scan_code)
      8'h1D:   p1_req = 2'b00;
      8'h23:   p1_req = 2'b01;
      8'h1B:   p1_req = 2'b10;
      8'h1C:   p1_req = 2'b11;
      default: p1_req_v = 1'b0;
    endcase
    p2_req_v = 1'b1;
    p2_req   = 2'b00;
    case (scan_code)
      8'h75:   p2_req = 2'b00;
      8'h74:   p2_req = 2'b01;
      8'h72:   p2_req = 2'b10;
      8'h6B:   p2_req = 2'b11;
      default: p2_req_v = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this
    // block can leave a value unassigned and infer a latch.
    state_d     = state_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    timer_d     = timer_q;
    read_d      = 1'b0;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_break_d = key_break_q;
    key_ext_d   = key_ext_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    start_d     = 1'b0;
    esc_d       = 1'b0;

    // The prefix timer runs while a prefix is pending. It silently drops
    // the prefix once it reaches PREFIX_TIMEOUT. A byte capture on the
    // same edge overrides this below.
    if (ext_q || brk_q) begin
      if (32'(timer_q) + 32'd1 >= PREFIX_TIMEOUT) begin
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (scan_ready) begin
          state_d = WAIT_CLR;
          read_d  = 1'b1;
          if (scan_code == 8'hE0) begin
            ext_d   = 1'b1;
            brk_d   = brk_q;
            timer_d = '0;
          end else if (scan_code == 8'hF0) begin
            ext_d   = ext_q;
            brk_d   = 1'b1;
            timer_d = '0;
          end else begin
            // The event reports the prefixes seen before this byte, not
            // whatever the timer logic above computed for this edge.
            key_valid_d = 1'b1;
            key_code_d  = scan_code;
            key_break_d = brk_q;
            key_ext_d   = ext_q;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
            timer_d     = '0;
            if (!brk_q) begin
              // A request for the reversed heading (dir ^ 2'b10) is ignored.
              if (!ext_q && p1_req_v && (p1_req != (p1_q ^ 2'b10))) p1_d = p1_req;
              if (ext_q && p2_req_v && (p2_req != (p2_q ^ 2'b10))) p2_d = p2_req;
              start_d = !ext_q && (scan_code == 8'h29);
              esc_d   = !ext_q && (scan_code == 8'h76);
            end
          end
        end
      end
      WAIT_CLR: begin
        if (!scan_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // flops update together from values computed in the previous cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      timer_q     <= '0;
      read_q      <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_break_q <= 1'b0;
      key_ext_q   <= 1'b0;
      p1_q        <= 2'b01;
      p2_q        <= 2'b11;
      start_q     <= 1'b0;
      esc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      timer_q     <= timer_d;
      read_q      <= read_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_break_q <= key_break_d;
      key_ext_q   <= key_ext_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      start_q     <= start_d;
      esc_q       <= esc_d;
    end
  end

  assign read        = read_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_break   = key_break_q;
  assign key_ext     = key_ext_q;
  assign p1_dir      = p1_q;
  assign p2_dir      = p2_q;
  assign start_pulse = start_q;
  assign esc_pulse   = esc_q;

endmodule
